// File: rtl/fifo_pkg.sv
// Shared defaults for the synchronous FIFO: data width, depth and read-mode encodings.
package fifo_pkg;
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_DEPTH_BITS = 3;

    // Read-mode selector values for the FWFT parameter
    localparam int FWFT_OFF = 0;
    localparam int FWFT_ON  = 1;

    function automatic int fifo_depth(input int depth_bits);
        return 1 << depth_bits;
    endfunction
endpackage

// File: rtl/fifo_if.sv
// Push/pop handshake, read data and status bundle between a FIFO user and fifo_sync.
interface fifo_if #(
    parameter int DATA_WIDTH = fifo_pkg::DEFAULT_DATA_WIDTH,
    parameter int DEPTH_BITS = fifo_pkg::DEFAULT_DEPTH_BITS
) ();
    logic [DATA_WIDTH-1:0] data;
    logic                  write_enable;
    logic                  read_enable;
    logic [DATA_WIDTH-1:0] q;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [DEPTH_BITS:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output data, write_enable, read_enable,
        input  q, fifo_full, fifo_empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  data, write_enable, read_enable,
        output q, fifo_full, fifo_empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_ram.sv
// FIFO storage: one synchronous write port and one asynchronous read port; contents never cleared.
module fifo_ram #(
    parameter int DATA_WIDTH = fifo_pkg::DEFAULT_DATA_WIDTH,
    parameter int ADDR_BITS  = fifo_pkg::DEFAULT_DEPTH_BITS
) (
    input  logic                  clock,
    input  logic                  write_enable,
    input  logic [ADDR_BITS-1:0]  write_address,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_BITS-1:0]  read_address,
    output logic [DATA_WIDTH-1:0] read_data
);
    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_BITS)-1];

    always_ff @(posedge clock) begin
        if (write_enable) begin
            mem[write_address] <= write_data;
        end
    end

    // Combinational read lets a same-edge read see the entry being overwritten when full.
    assign read_data = mem[read_address];
endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO control: pointers, occupancy, status flags and registered or FWFT read data.
module fifo_sync
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH         = DEFAULT_DATA_WIDTH,
    parameter int DEPTH_BITS         = DEFAULT_DEPTH_BITS,
    parameter int ALMOST_FULL_LEVEL  = fifo_depth(DEPTH_BITS) - 1,
    parameter int ALMOST_EMPTY_LEVEL = 1,
    parameter int FWFT               = FWFT_OFF
) (
    input  logic  clock,
    input  logic  reset,
    fifo_if.slave bus
);
    localparam int CNT_W = DEPTH_BITS + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(fifo_depth(DEPTH_BITS));
    localparam logic [CNT_W-1:0] AF_LEVEL  = CNT_W'(ALMOST_FULL_LEVEL);
    localparam logic [CNT_W-1:0] AE_LEVEL  = CNT_W'(ALMOST_EMPTY_LEVEL);

    logic [DEPTH_BITS-1:0] write_pointer_reg, write_pointer_next;
    logic [DEPTH_BITS-1:0] read_pointer_reg, read_pointer_next;
    logic [CNT_W-1:0]      count_reg, count_next;
    logic                  overflow_reg, overflow_next;
    logic                  underflow_reg, underflow_next;
    logic                  full, empty, wr_ok, rd_ok;
    logic [DATA_WIDTH-1:0] head_data;

    // Flags decode only registered count, never the current enables.
    assign full  = (count_reg == DEPTH_CNT);
    assign empty = (count_reg == '0);
    assign rd_ok = bus.read_enable & ~empty;
    assign wr_ok = bus.write_enable & (~full | rd_ok);

    always_comb begin
        write_pointer_next = write_pointer_reg;
        read_pointer_next  = read_pointer_reg;
        count_next         = count_reg;
        overflow_next      = overflow_reg | (bus.write_enable & ~wr_ok);
        underflow_next     = underflow_reg | (bus.read_enable & ~rd_ok);
        if (wr_ok) write_pointer_next = write_pointer_reg + 1'b1;
        if (rd_ok) read_pointer_next  = read_pointer_reg + 1'b1;
        case ({wr_ok, rd_ok})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            write_pointer_reg <= '0;
            read_pointer_reg  <= '0;
            count_reg         <= '0;
            overflow_reg      <= 1'b0;
            underflow_reg     <= 1'b0;
        end else begin
            write_pointer_reg <= write_pointer_next;
            read_pointer_reg  <= read_pointer_next;
            count_reg         <= count_next;
            overflow_reg      <= overflow_next;
            underflow_reg     <= underflow_next;
        end
    end

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_BITS  (DEPTH_BITS)
    ) u_ram (
        .clock         (clock),
        .write_enable  (wr_ok & ~reset),
        .write_address (write_pointer_reg),
        .write_data    (bus.data),
        .read_address  (read_pointer_reg),
        .read_data     (head_data)
    );

    generate
        if (FWFT == FWFT_OFF) begin : g_registered_read
            logic [DATA_WIDTH-1:0] q_reg;
            always_ff @(posedge clock) begin
                if (reset) begin
                    q_reg <= '0;
                end else if (rd_ok) begin
                    q_reg <= head_data;
                end
            end
            assign bus.q = q_reg;
        end else begin : g_fwft_read
            assign bus.q = head_data;
        end
    endgenerate

    assign bus.fifo_full    = full;
    assign bus.fifo_empty   = empty;
    assign bus.almost_full  = (count_reg >= AF_LEVEL);
    assign bus.almost_empty = (count_reg <= AE_LEVEL);
    assign bus.count        = count_reg;
    assign bus.overflow     = overflow_reg;
    assign bus.underflow    = underflow_reg;
endmodule

// File: tb/tb_fifo_sync.sv
// Directed checks of fifo_sync (8-bit, 8-deep) in registered-read and FWFT builds.
module tb_fifo_sync;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   passed = 0;
    int   total  = 0;

    always #5 clock = ~clock;

    fifo_if #(.DATA_WIDTH(8), .DEPTH_BITS(3)) bus_a ();
    fifo_if #(.DATA_WIDTH(8), .DEPTH_BITS(3)) bus_b ();

    fifo_sync #(.DATA_WIDTH(8), .DEPTH_BITS(3), .FWFT(0)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    fifo_sync #(.DATA_WIDTH(8), .DEPTH_BITS(3), .FWFT(1)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) begin
            passed++;
        end else begin
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step(input logic we, input logic re, input logic [7:0] d);
        bus_a.write_enable = we;
        bus_a.read_enable  = re;
        bus_a.data         = d;
        @(posedge clock);
        #1;
        bus_a.write_enable = 1'b0;
        bus_a.read_enable  = 1'b0;
    endtask

    task automatic step_b(input logic we, input logic re, input logic [7:0] d);
        bus_b.write_enable = we;
        bus_b.read_enable  = re;
        bus_b.data         = d;
        @(posedge clock);
        #1;
        bus_b.write_enable = 1'b0;
        bus_b.read_enable  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 1'b0, 8'h00);
        reset = 1'b0;
    endtask

    initial begin
        bus_a.write_enable = 1'b0;
        bus_a.read_enable  = 1'b0;
        bus_a.data         = 8'h00;
        bus_b.write_enable = 1'b0;
        bus_b.read_enable  = 1'b0;
        bus_b.data         = 8'h00;

        // Reset state
        do_reset();
        check("rst_count", bus_a.count, 0);
        check("rst_empty", bus_a.fifo_empty, 1);
        check("rst_full", bus_a.fifo_full, 0);
        check("rst_aempty", bus_a.almost_empty, 1);
        check("rst_afull", bus_a.almost_full, 0);
        check("rst_overflow", bus_a.overflow, 0);
        check("rst_underflow", bus_a.underflow, 0);
        check("rst_q", bus_a.q, 8'h00);
        $display("reset: count=%0d empty=%0b q=0x%02h", bus_a.count, bus_a.fifo_empty, bus_a.q);

        // Read from empty
        step(1'b0, 1'b1, 8'h00);
        check("underflow_set", bus_a.underflow, 1);
        check("underflow_count", bus_a.count, 0);
        check("underflow_q", bus_a.q, 8'h00);
        $display("read empty: underflow=%0b count=%0d q=0x%02h", bus_a.underflow, bus_a.count, bus_a.q);

        // Fill with 0x01..0x08
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 1'b0, 8'(k));
            check($sformatf("fill_count_%0d", k), bus_a.count, k);
            check($sformatf("fill_afull_%0d", k), bus_a.almost_full, (k >= 7) ? 1 : 0);
            check($sformatf("fill_aempty_%0d", k), bus_a.almost_empty, (k <= 1) ? 1 : 0);
            check($sformatf("fill_full_%0d", k), bus_a.fifo_full, (k == 8) ? 1 : 0);
            $display("write 0x%02h: count=%0d afull=%0b full=%0b", k, bus_a.count, bus_a.almost_full, bus_a.fifo_full);
        end

        // Ninth write rejected
        step(1'b1, 1'b0, 8'h09);
        check("ovf_set", bus_a.overflow, 1);
        check("ovf_count", bus_a.count, 8);
        $display("write 0x09 full: overflow=%0b count=%0d", bus_a.overflow, bus_a.count);

        // Full: simultaneous write 0xAA and read
        step(1'b1, 1'b1, 8'hAA);
        check("fullrw_count", bus_a.count, 8);
        check("fullrw_q", bus_a.q, 8'h01);
        check("fullrw_full", bus_a.fifo_full, 1);
        $display("full rw 0xAA: count=%0d q=0x%02h", bus_a.count, bus_a.q);

        // Drain: 0x02..0x08 then 0xAA
        for (int k = 2; k <= 9; k++) begin
            logic [7:0] exp_q;
            exp_q = (k == 9) ? 8'hAA : 8'(k);
            step(1'b0, 1'b1, 8'h00);
            check($sformatf("drain_q_%0d", k), bus_a.q, exp_q);
            $display("read: q=0x%02h count=%0d", bus_a.q, bus_a.count);
        end
        check("drain_empty", bus_a.fifo_empty, 1);
        check("drain_count", bus_a.count, 0);

        // Empty: simultaneous write 0x55 and read
        step(1'b1, 1'b1, 8'h55);
        check("emptyrw_count", bus_a.count, 1);
        check("emptyrw_empty", bus_a.fifo_empty, 0);
        check("emptyrw_underflow", bus_a.underflow, 1);
        check("emptyrw_q_hold", bus_a.q, 8'hAA);
        $display("empty rw 0x55: count=%0d underflow=%0b q=0x%02h", bus_a.count, bus_a.underflow, bus_a.q);
        step(1'b0, 1'b1, 8'h00);
        check("emptyrw_readback", bus_a.q, 8'h55);
        check("emptyrw_count0", bus_a.count, 0);
        $display("read: q=0x%02h count=%0d", bus_a.q, bus_a.count);

        // Reset at count 5, with a write pending on the reset edge
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 8'(8'h10 + k));
        check("pre_reset_count", bus_a.count, 5);
        reset = 1'b1;
        step(1'b1, 1'b0, 8'h99);
        reset = 1'b0;
        check("midrst_count", bus_a.count, 0);
        check("midrst_empty", bus_a.fifo_empty, 1);
        check("midrst_overflow", bus_a.overflow, 0);
        check("midrst_underflow", bus_a.underflow, 0);
        check("midrst_q", bus_a.q, 8'h00);
        $display("mid reset: count=%0d empty=%0b", bus_a.count, bus_a.fifo_empty);
        step(1'b1, 1'b0, 8'h33);
        step(1'b0, 1'b1, 8'h00);
        check("postrst_q", bus_a.q, 8'h33);
        $display("post reset read: q=0x%02h", bus_a.q);

        // Interleaved 12 writes / 12 reads, wrapping both pointers
        step(1'b1, 1'b0, 8'h40);
        for (int k = 1; k < 12; k++) begin
            step(1'b1, 1'b1, 8'(8'h40 + k));
            check($sformatf("wrap_q_%0d", k - 1), bus_a.q, 8'(8'h40 + k - 1));
            check($sformatf("wrap_count_%0d", k), bus_a.count, 1);
            $display("wrap rw: q=0x%02h count=%0d", bus_a.q, bus_a.count);
        end
        step(1'b0, 1'b1, 8'h00);
        check("wrap_q_11", bus_a.q, 8'h4B);
        check("wrap_empty", bus_a.fifo_empty, 1);
        $display("wrap last read: q=0x%02h", bus_a.q);

        // FWFT build
        do_reset();
        check("fwft_rst_empty", bus_b.fifo_empty, 1);
        step_b(1'b1, 1'b0, 8'h01);
        check("fwft_q_first", bus_b.q, 8'h01);
        check("fwft_not_empty", bus_b.fifo_empty, 0);
        $display("fwft write 0x01: q=0x%02h", bus_b.q);
        step_b(1'b1, 1'b0, 8'h02);
        check("fwft_q_hold", bus_b.q, 8'h01);
        step_b(1'b0, 1'b1, 8'h00);
        check("fwft_q_next", bus_b.q, 8'h02);
        check("fwft_count", bus_b.count, 1);
        $display("fwft read: q=0x%02h count=%0d", bus_b.q, bus_b.count);
        step_b(1'b0, 1'b1, 8'h00);
        check("fwft_empty", bus_b.fifo_empty, 1);
        $display("fwft read: empty=%0b", bus_b.fifo_empty);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
